rf_wb_arbiter: RTL and testbench



---
 rtl/rf_wb_arbiter_if.sv | 48 ++++
 rtl/rf_wb_arbiter.sv | 119 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle around the register-file write-port arbiter: WB stage, long-latency
// result stream, issue/decode scoreboard taps and the RF write port.
interface rf_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              p_valid;
    logic              p_we;
    logic [ADDR_W-1:0] p_rd;
    logic [DATA_W-1:0] p_data;
    logic              wb_stall;

    logic              lu_valid;
    logic              lu_ready;
    logic [ADDR_W-1:0] lu_rd;
    logic [DATA_W-1:0] lu_data;

    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rd;

    logic              id_valid;
    logic [ADDR_W-1:0] id_rs1;
    logic [ADDR_W-1:0] id_rs2;
    logic [ADDR_W-1:0] id_rd;
    logic              hazard_stall;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;

    modport slave (
        input  p_valid, p_we, p_rd, p_data,
        input  lu_valid, lu_rd, lu_data,
        input  iss_valid, iss_rd,
        input  id_valid, id_rs1, id_rs2, id_rd,
        output wb_stall, lu_ready, hazard_stall,
        output rf_we, rf_wa, rf_wd
    );

    modport master (
        output p_valid, p_we, p_rd, p_data,
        output lu_valid, lu_rd, lu_data,
        output iss_valid, iss_rd,
        output id_valid, id_rs1, id_rs2, id_rd,
        input  wb_stall, lu_ready, hazard_stall,
        input  rf_we, rf_wa, rf_wd
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: WB stage vs long-latency results, one-entry hold
// buffer, starvation drain and pending-destination scoreboard. RF_WB_STAT_EN adds a conflict counter.
module rf_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_LIM = 4
) (
    input  logic                clk,
    input  logic                rst,
    rf_wb_arbiter_if.slave      bus,
    output logic [31:0]         stat_conflicts
);
    localparam int NREG = 2 ** ADDR_W;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

    typedef enum logic [1:0] {SRC_NONE, SRC_PIPE, SRC_BUF, SRC_LU} src_t;

    logic              buf_v_reg;
    logic [ADDR_W-1:0] buf_rd_reg;
    logic [DATA_W-1:0] buf_data_reg;
    logic [3:0]        starve_reg;
    logic [NREG-1:0]   pend_reg;
    logic [NREG-1:0]   pend_next;

    src_t              src;
    logic              p_wr;
    logic              starved;
    logic              buf_wr;
    logic              ll_wr;
    logic              lu_ready_int;
    logic              lu_acc;
    logic              buf_load;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    always_comb begin
        p_wr    = bus.p_valid && bus.p_we;
        starved = buf_v_reg && (starve_reg == STARVE_MAX);
        src     = SRC_NONE;
        wr_addr = '0;
        wr_data = '0;
        // Starvation drain outranks the pipeline; otherwise the pipeline wins
        if (starved)           src = SRC_BUF;
        else if (p_wr)         src = SRC_PIPE;
        else if (buf_v_reg)    src = SRC_BUF;
        else if (bus.lu_valid) src = SRC_LU;
        case (src)
            SRC_PIPE: begin wr_addr = bus.p_rd;   wr_data = bus.p_data;   end
            SRC_BUF:  begin wr_addr = buf_rd_reg; wr_data = buf_data_reg; end
            SRC_LU:   begin wr_addr = bus.lu_rd;  wr_data = bus.lu_data;  end
            default:  ;
        endcase
        buf_wr       = (src == SRC_BUF);
        ll_wr        = (src == SRC_BUF) || (src == SRC_LU);
        lu_ready_int = !buf_v_reg || buf_wr;
        lu_acc       = bus.lu_valid && lu_ready_int;
        buf_load     = lu_acc && (src != SRC_LU);
    end

    assign bus.wb_stall     = starved;
    assign bus.lu_ready     = lu_ready_int;
    assign bus.rf_we        = (src != SRC_NONE) && (wr_addr != '0) && !rst;
    assign bus.rf_wa        = wr_addr;
    assign bus.rf_wd        = wr_data;
    assign bus.hazard_stall = bus.id_valid &&
                              (pend_reg[bus.id_rs1] || pend_reg[bus.id_rs2] || pend_reg[bus.id_rd]);

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_v_reg  <= 1'b0;
            starve_reg <= '0;
        end else begin
            // A reload in the same cycle as a drain keeps the buffer occupied
            if (buf_load) begin
                buf_v_reg    <= 1'b1;
                buf_rd_reg   <= bus.lu_rd;
                buf_data_reg <= bus.lu_data;
            end else if (buf_wr) begin
                buf_v_reg <= 1'b0;
            end
            if (buf_load || buf_wr)
                starve_reg <= '0;
            else if (buf_v_reg && starve_reg != STARVE_MAX)
                starve_reg <= starve_reg + 4'd1;
        end
    end

    // Issue sets a pending bit, a long-latency write clears it; set wins a tie
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pend_next[gi] = 1'b0;
            end else begin : g_reg
                assign pend_next[gi] =
                    (bus.iss_valid && bus.iss_rd == ADDR_W'(gi)) ||
                    (pend_reg[gi] && !(ll_wr && wr_addr == ADDR_W'(gi)));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) pend_reg <= '0;
        else     pend_reg <= pend_next;
    end

`ifdef RF_WB_STAT_EN
    logic [31:0] stat_reg;
    always_ff @(posedge clk) begin
        if (rst)
            stat_reg <= '0;
        else if ((bus.lu_valid && !lu_ready_int) || starved)
            stat_reg <= stat_reg + 32'd1;
    end
    assign stat_conflicts = stat_reg;
`else
    assign stat_conflicts = '0;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomised bench for rf_wb_arbiter against a queue-based reference model.
module tb_rf_wb_arbiter;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int STARVE_LIM = 4;
    localparam int NREG       = 2 ** ADDR_W;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] stat_conflicts;

    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIM(STARVE_LIM)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .stat_conflicts (stat_conflicts)
    );

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } res_t;

    // Reference model state
    res_t        m_buf[$];
    int          m_starve;
    bit          m_pend[NREG];
    logic [31:0] m_stat;

    // Per-cycle expectations (src: 0 none, 1 pipeline, 2 buffer, 3 direct lu)
    int                src;
    logic              e_we, e_stall, e_ready, e_haz;
    logic [ADDR_W-1:0] e_wa;
    logic [DATA_W-1:0] e_wd;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_eval();
        bit has_buf;
        bit p_wr;
        has_buf = (m_buf.size() != 0);
        p_wr    = bus.p_valid && bus.p_we;
        e_stall = has_buf && (m_starve == STARVE_LIM);
        src = 0;
        if (e_stall)           src = 2;
        else if (p_wr)         src = 1;
        else if (has_buf)      src = 2;
        else if (bus.lu_valid) src = 3;
        e_wa = '0;
        e_wd = '0;
        if (src == 1) begin e_wa = bus.p_rd;    e_wd = bus.p_data;    end
        if (src == 2) begin e_wa = m_buf[0].rd; e_wd = m_buf[0].data; end
        if (src == 3) begin e_wa = bus.lu_rd;   e_wd = bus.lu_data;   end
        e_we    = (src != 0) && (e_wa != 0) && !rst;
        e_ready = !has_buf || (src == 2);
        e_haz   = bus.id_valid && (m_pend[bus.id_rs1] || m_pend[bus.id_rs2] || m_pend[bus.id_rd]);
    endtask

    task automatic model_update();
        bit loaded;
        if (rst) begin
            m_buf.delete();
            m_starve = 0;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_stat = '0;
        end else begin
`ifdef RF_WB_STAT_EN
            if ((bus.lu_valid && !e_ready) || e_stall) m_stat = m_stat + 1;
`endif
            loaded = bus.lu_valid && e_ready && (src != 3);
            if (src == 2 || src == 3) m_pend[e_wa] = 1'b0;
            if (bus.iss_valid && bus.iss_rd != 0) m_pend[bus.iss_rd] = 1'b1;
            if (src == 2) void'(m_buf.pop_front());
            if (loaded) m_buf.push_back('{rd: bus.lu_rd, data: bus.lu_data});
            if (src == 2 || loaded) m_starve = 0;
            else if (m_buf.size() != 0 && m_starve < STARVE_LIM) m_starve++;
        end
    endtask

    // Called at a falling edge with inputs already driven
    task automatic step();
        #1;
        model_eval();
        check("wb_stall", bus.wb_stall, e_stall);
        check("lu_ready", bus.lu_ready, e_ready);
        check("hazard_stall", bus.hazard_stall, e_haz);
        check("rf_we", bus.rf_we, e_we);
        if (e_we) begin
            check("rf_wa", bus.rf_wa, e_wa);
            check("rf_wd", bus.rf_wd, e_wd);
        end
        check("stat_conflicts", stat_conflicts, m_stat);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_in();
        bus.p_valid   = 0; bus.p_we = 0; bus.p_rd = '0; bus.p_data = '0;
        bus.lu_valid  = 0; bus.lu_rd = '0; bus.lu_data = '0;
        bus.iss_valid = 0; bus.iss_rd = '0;
        bus.id_valid  = 0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
    endtask

    task automatic drive_p(input int rd, input int data);
        bus.p_valid = 1; bus.p_we = 1; bus.p_rd = ADDR_W'(rd); bus.p_data = DATA_W'(data);
    endtask

    task automatic drive_lu(input int rd, input int data);
        bus.lu_valid = 1; bus.lu_rd = ADDR_W'(rd); bus.lu_data = DATA_W'(data);
    endtask

    initial begin
        bit hold_p;
        bit hold_lu;
        int r;
        m_stat = '0;
        m_starve = 0;
        clear_in();
        rst = 1;
        @(negedge clk);
        step();
        step();
        rst = 0;

        // Idle after reset
        step();

        // Lone pipeline write
        drive_p(5, 'h11);
        #1;
        check("t1_rf_wa", bus.rf_wa, 5);
        check("t1_rf_wd", bus.rf_wd, 'h11);
        step();

        // Collision: pipeline wins, lu result deferred and written next cycle
        drive_p(3, 'hA); drive_lu(7, 'hB);
        step();
        clear_in();
        #1;
        check("t2_rf_wa", bus.rf_wa, 7);
        check("t2_rf_wd", bus.rf_wd, 'hB);
        step();

        // Buffer full with a second result waiting; x7 must precede x8
        drive_p(3, 'h1); drive_lu(7, 'h77);
        step();
        drive_p(4, 'h2); drive_lu(8, 'h88);
        #1;
        check("t3_lu_ready_blocked", bus.lu_ready, 0);
        step();
        bus.p_valid = 0;
        #1;
        check("t3_first_wa", bus.rf_wa, 7);
        step();
        clear_in();
        #1;
        check("t3_second_wa", bus.rf_wa, 8);
        step();

        // Starvation: buffered x9 drains after STARVE_LIM waiting cycles
        drive_p(1, 'h100); drive_lu(9, 'h99);
        step();
        bus.lu_valid = 0;
        for (int i = 0; i < STARVE_LIM; i++) begin
            drive_p(10 + i, 'h200 + i);
            step();
        end
        drive_p(20, 'h300);
        #1;
        check("t4_wb_stall", bus.wb_stall, 1);
        check("t4_drain_wa", bus.rf_wa, 9);
        step();
        step();
        clear_in();

        // Scoreboard: issue x6, decode reads x6, lu write clears, tie keeps set
        bus.iss_valid = 1; bus.iss_rd = 6;
        step();
        bus.iss_valid = 0;
        bus.id_valid = 1; bus.id_rs1 = 0; bus.id_rs2 = 6; bus.id_rd = 0;
        #1;
        check("t5_hazard", bus.hazard_stall, 1);
        step();
        drive_lu(6, 'h66);
        step();
        bus.lu_valid = 0;
        #1;
        check("t5_hazard_clear", bus.hazard_stall, 0);
        step();
        bus.iss_valid = 1; bus.iss_rd = 6; drive_lu(6, 'h67);
        step();
        bus.iss_valid = 0;
        drive_lu(0, 'h5);
        #1;
        check("t5_pend_kept", bus.hazard_stall, 1);
        check("t5_x0_we", bus.rf_we, 0);
        step();
        drive_lu(6, 'h68);
        step();
        clear_in();
        step();

        // Randomised traffic with protocol-respecting holds and sporadic resets
        hold_p = 0;
        hold_lu = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (!hold_p) begin
                bus.p_valid = ($urandom_range(0, 99) < 80);
                bus.p_we    = ($urandom_range(0, 99) < 85);
                bus.p_rd    = ADDR_W'($urandom);
                bus.p_data  = DATA_W'($urandom);
            end
            if (!hold_lu) begin
                bus.lu_valid = ($urandom_range(0, 99) < 45);
                bus.lu_rd    = ADDR_W'($urandom);
                bus.lu_data  = DATA_W'($urandom);
            end
            r = $urandom_range(0, NREG - 1);
            bus.iss_rd    = ADDR_W'(r);
            bus.iss_valid = ($urandom_range(0, 9) < 3) && !m_pend[r];
            bus.id_valid  = $urandom_range(0, 1) == 1;
            bus.id_rs1    = ADDR_W'($urandom);
            bus.id_rs2    = ADDR_W'($urandom);
            bus.id_rd     = ADDR_W'($urandom);
            step();
            hold_p  = !rst && e_stall;
            hold_lu = !rst && bus.lu_valid && !e_ready;
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
